serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Sequencer that sits directly upstream and downstream of the 1-bit serial adder.
- Accepts two parallel operands through a valid/ready handshake and shifts them LSB-first into the adder, one bit per clock.
- Owns the carry register between bit-slices.
- Collects the sum bits back into a parallel result with carry and overflow flags, presented on an output valid/ready handshake.
- Supports add and subtract (two's complement: invert b, carry-in 1).

Parameters:
- length, 8, operand/result width in bits (≥2).

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_data_a  input  length  operand a
- i_data_b  input  length  operand b
- i_con_sub  input  1  0 = a+b, 1 = a-b; sampled with operands
- i_valid  input  1  operands valid
- o_ready  output  1  sequencer can accept operands
- o_bit_a  output  1  current a bit to adder
- o_bit_b  output  1  current b bit to adder (already inverted for subtract)
- o_bit_cin  output  1  carry-in to adder
- i_bit_sum  input  1  adder sum bit (combinational from o_bit_*)
- i_bit_cout  input  1  adder carry-out
- o_data_result  output  length  parallel result
- o_flag_c  output  1  final carry-out (subtract: 1 = no borrow)
- o_flag_v  output  1  signed overflow
- o_valid  output  1  result valid
- i_ready  input  1  consumer accepts result

Behaviour:
- Reset (i_rst_n low, async) forces the following, and holds them while low:
  - state IDLE
  - operand shift registers, result register and carry register all 0
  - bit counter 0
  - o_data_result, o_flag_c, o_flag_v and o_valid 0
  - o_bit_a, o_bit_b and o_bit_cin 0
  - o_ready 1 (o_ready is decoded from IDLE).
- States IDLE, SHIFT, DONE. o_ready = (state==IDLE); o_valid = (state==DONE).

IDLE:
- On i_valid && o_ready, latch the operands and go to SHIFT:
  - a_sr <= i_data_a
  - b_sr <= i_con_sub ? ~i_data_b : i_data_b
  - carry <= i_con_sub
  - cnt <= 0
- Otherwise hold.

SHIFT:
- Drive o_bit_a = a_sr[0], o_bit_b = b_sr[0], o_bit_cin = carry.
- Each clock:
  - shift a_sr and b_sr right by 1
  - shift i_bit_sum into the result register MSB, shifting right, so bit k lands at position k after length shifts
  - carry <= i_bit_cout
  - cnt <= cnt+1
- When cnt == length-1:
  - capture o_flag_c <= i_bit_cout
  - capture o_flag_v <= carry ^ i_bit_cout (carry into MSB xor carry out of MSB)
  - go to DONE
- Exactly length cycles in SHIFT. Latency from accepting handshake edge to o_valid high = length+1 rising edges.

DONE:
- o_data_result, o_flag_c and o_flag_v are stable and held.
- On i_ready, go to IDLE. The result registers keep their value until the next operation overwrites them.
- o_ready is low in DONE, so there is no overlap of a new accept with an unread result. Minimum issue interval is length+2 cycles with i_ready tied high.

Adder outputs outside SHIFT:
- In IDLE and DONE, o_bit_a, o_bit_b and o_bit_cin are 0.

Input stability:
- i_data_a, i_data_b and i_con_sub are don't-care except on the accept cycle.
- i_valid may drop without acceptance; no state change results.

Asserting reset mid-SHIFT or in DONE:
- Aborts immediately to the reset values.
- The partial result is discarded and never presented.
- After release, the block accepts a fresh operation on the first edge with i_valid high.

Counter:
- Width is $clog2(length); it wraps only via the state transition.

Combinational timing:
- i_bit_sum and i_bit_cout must be combinational functions of o_bit_* within the same cycle; there are no internal combinational loops.

Test Plan (length=8, bench models the adder as a full adder):
- Add 0x35+0x1C, i_ready=1 -> o_valid on 9th edge after accept; result 0x51, c=0, v=0; o_ready returns 1 the cycle after.
- Add 0xFF+0x01 -> result 0x00, c=1, v=0.
- Add 0x7F+0x01 -> result 0x80, c=0, v=1.
- Sub 0x10-0x20 -> result 0xF0, c=0, v=0. Sub 0x80-0x01 -> result 0x7F, c=1, v=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and the result remain stable; o_ready stays 0; i_valid pulses are ignored. Raising i_ready -> IDLE next edge.
- Reset: assert i_rst_n=0 at bit 3 of 0x35+0x1C -> all outputs take reset values asynchronously (o_ready=1, o_valid=0). Next op 0x02+0x03 -> result 0x05 with no residue.

Source files
------------

// File: rtl/serial_add_seq_if.sv
// Bundles the sequencer's operand, adder-slice and result handshakes into one port.
// master is the sequencer's view; slave is the surrounding producer/adder/consumer.
interface serial_add_seq_if #(
  parameter int length = 8
);
  logic [length-1:0] i_data_a;
  logic [length-1:0] i_data_b;
  logic              i_con_sub;
  logic              i_valid;
  logic              o_ready;
  logic              o_bit_a;
  logic              o_bit_b;
  logic              o_bit_cin;
  logic              i_bit_sum;
  logic              i_bit_cout;
  logic [length-1:0] o_data_result;
  logic              o_flag_c;
  logic              o_flag_v;
  logic              o_valid;
  logic              i_ready;

  modport master (
    input  i_data_a, i_data_b, i_con_sub, i_valid,
    output o_ready,
    output o_bit_a, o_bit_b, o_bit_cin,
    input  i_bit_sum, i_bit_cout,
    output o_data_result, o_flag_c, o_flag_v, o_valid,
    input  i_ready
  );

  modport slave (
    output i_data_a, i_data_b, i_con_sub, i_valid,
    input  o_ready,
    input  o_bit_a, o_bit_b, o_bit_cin,
    output i_bit_sum, i_bit_cout,
    input  o_data_result, o_flag_c, o_flag_v, o_valid,
    output i_ready
  );
endinterface

// File: rtl/serial_add_seq.sv
// Feeds two parallel operands LSB-first through an external 1-bit adder and
// gathers the sum bits back into a parallel result with carry/overflow flags.
module serial_add_seq #(
  parameter int length = 8
) (
  input logic             i_clk,
  input logic             i_rst_n,
  serial_add_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int cnt_w = (length > 1) ? $clog2(length) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(length - 1);

  state_t            state;
  state_t            next_state;
  logic [length-1:0] a_sr;
  logic [length-1:0] b_sr;
  logic [length-1:0] result;
  logic              carry;
  logic [cnt_w-1:0]  cnt;
  logic              flag_c;
  logic              flag_v;
  logic              accept;
  logic              last_bit;

  assign accept   = bus.i_valid && (state == IDLE);
  assign last_bit = (cnt == cnt_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // Adder inputs are gated to zero outside SHIFT so the slice idles quietly.
  always_comb begin
    next_state    = state;
    bus.o_ready   = 1'b0;
    bus.o_valid   = 1'b0;
    bus.o_bit_a   = 1'b0;
    bus.o_bit_b   = 1'b0;
    bus.o_bit_cin = 1'b0;
    case (state)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) next_state = SHIFT;
      end
      SHIFT: begin
        bus.o_bit_a   = a_sr[0];
        bus.o_bit_b   = b_sr[0];
        bus.o_bit_cin = carry;
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: b is inverted on load and the carry seeded with 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      result <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr  <= bus.i_data_a;
            b_sr  <= bus.i_con_sub ? ~bus.i_data_b : bus.i_data_b;
            carry <= bus.i_con_sub;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= {1'b0, a_sr[length-1:1]};
          b_sr   <= {1'b0, b_sr[length-1:1]};
          result <= {bus.i_bit_sum, result[length-1:1]};
          carry  <= bus.i_bit_cout;
          cnt    <= cnt + cnt_w'(1);
          // Overflow compares the carry into the MSB slice with the carry out of it.
          if (last_bit) begin
            flag_c <= bus.i_bit_cout;
            flag_v <= carry ^ bus.i_bit_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_data_result = result;
  assign bus.o_flag_c      = flag_c;
  assign bus.o_flag_v      = flag_v;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a full-adder model on the bit interface
// and a queue-based scoreboard checking each presented result.
module tb_serial_add_seq;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  exp_t exp_q[$];

  serial_add_seq_if #(.length(8)) bus_if ();

  serial_add_seq #(.length(8)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_if)
  );

  assign bus_if.i_bit_sum  = bus_if.o_bit_a ^ bus_if.o_bit_b ^ bus_if.o_bit_cin;
  assign bus_if.i_bit_cout = (bus_if.o_bit_a & bus_if.o_bit_b) |
                             (bus_if.o_bit_a & bus_if.o_bit_cin) |
                             (bus_if.o_bit_b & bus_if.o_bit_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expectation per result handshake.
  always @(negedge clk) begin
    if (rst_n && bus_if.o_valid && bus_if.i_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_result: got %h with no pending expectation", bus_if.o_data_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_byte("result", bus_if.o_data_result, e.res);
        check_bit("flag_c", bus_if.o_flag_c, e.c);
        check_bit("flag_v", bus_if.o_flag_v, e.v);
      end
    end
  end

  // Issues one operation; returns 1 time unit after the accepting edge.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int guard;
    logic [7:0] a_v;
    logic [7:0] b_v;
    a_v   = a;
    b_v   = b;
    guard = 0;
    while (!bus_if.o_ready && guard < 30) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!bus_if.o_ready) check_bit("ready_timeout", bus_if.o_ready, 1'b1);
    bus_if.i_data_a  = a;
    bus_if.i_data_b  = b;
    bus_if.i_con_sub = sub;
    bus_if.i_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.i_valid   = 1'b0;
    bus_if.i_data_a  = 8'hxx;
    bus_if.i_data_b  = 8'hxx;
    bus_if.i_con_sub = 1'bx;
    check_bit("bit_a_first", bus_if.o_bit_a, a_v[0]);
    check_bit("bit_b_first", bus_if.o_bit_b, sub ? ~b_v[0] : b_v[0]);
    check_bit("bit_cin_first", bus_if.o_bit_cin, sub);
  endtask

  // Counts edges, the accepting edge being 1, until o_valid is seen.
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus_if.o_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus_if.o_valid) check_bit("valid_timeout", bus_if.o_valid, 1'b1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [7:0] res, input logic c, input logic v);
    int n;
    exp_t e;
    e.res = res;
    e.c   = c;
    e.v   = v;
    exp_q.push_back(e);
    apply_stimulus(a, b, sub);
    wait_valid(n);
    check_int("latency", n, 9);
    check_bit("ready_in_done", bus_if.o_ready, 1'b0);
    @(posedge clk);
    #1;
    check_bit("ready_after_done", bus_if.o_ready, 1'b1);
    check_bit("valid_after_done", bus_if.o_valid, 1'b0);
  endtask

  initial begin
    int n;
    logic [7:0] held;
    compared   = 0;
    mismatched = 0;
    rst_n            = 1'b0;
    bus_if.i_data_a  = 8'h00;
    bus_if.i_data_b  = 8'h00;
    bus_if.i_con_sub = 1'b0;
    bus_if.i_valid   = 1'b0;
    bus_if.i_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_ready", bus_if.o_ready, 1'b1);
    check_bit("reset_valid", bus_if.o_valid, 1'b0);
    check_byte("reset_result", bus_if.o_data_result, 8'h00);
    check_bit("reset_cin", bus_if.o_bit_cin, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(8'h35, 8'h1C, 1'b0, 8'h51, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0);

    // Backpressure: result must hold while the consumer stalls.
    bus_if.i_ready = 1'b0;
    exp_q.push_back('{res: 8'h69, c: 1'b0, v: 1'b0});
    apply_stimulus(8'h5A, 8'h0F, 1'b0);
    wait_valid(n);
    check_int("bp_latency", n, 9);
    held = bus_if.o_data_result;
    check_byte("bp_result_first", held, 8'h69);
    for (int i = 0; i < 5; i++) begin
      bus_if.i_valid   = 1'b1;
      bus_if.i_data_a  = 8'hA5;
      bus_if.i_data_b  = 8'h3C;
      bus_if.i_con_sub = 1'b1;
      @(posedge clk);
      #1;
      bus_if.i_valid = 1'b0;
      check_bit("bp_valid", bus_if.o_valid, 1'b1);
      check_bit("bp_ready", bus_if.o_ready, 1'b0);
      check_byte("bp_result", bus_if.o_data_result, 8'h69);
      check_bit("bp_bit_a", bus_if.o_bit_a, 1'b0);
    end
    bus_if.i_ready = 1'b1;
    @(posedge clk);
    #1;
    check_bit("bp_release_ready", bus_if.o_ready, 1'b1);
    check_bit("bp_release_valid", bus_if.o_valid, 1'b0);

    // Reset mid-operation: partial result must vanish.
    apply_stimulus(8'h35, 8'h1C, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("abort_ready", bus_if.o_ready, 1'b1);
    check_bit("abort_valid", bus_if.o_valid, 1'b0);
    check_byte("abort_result", bus_if.o_data_result, 8'h00);
    check_bit("abort_flag_c", bus_if.o_flag_c, 1'b0);
    check_bit("abort_bit_a", bus_if.o_bit_a, 1'b0);
    check_bit("abort_bit_b", bus_if.o_bit_b, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
